// File: rtl/demultiplexor4bits_1_2_buf_pkg.sv
// Shared constants for the registered 1:2 demultiplexer: selector encoding,
// per-port buffer depth and statistics counter width.
package demultiplexor4bits_1_2_buf_pkg;

  localparam logic SEL_PORT1     = 1'b1;
  localparam logic SEL_PORT2     = 1'b0;
  localparam int   DEMUX_DEPTH   = 2;
  localparam int   DEMUX_STATS_W = 8;

endpackage

// File: rtl/demultiplexor4bits_1_2_buf_if.sv
// Producer/consumer bundle for the 1:2 demultiplexer. Defining DEMUX_STATS_EN
// adds the per-port accepted-word counters count1/count2.
interface demultiplexor4bits_1_2_buf_if #(
  parameter int WIDTH = 4
);
  import demultiplexor4bits_1_2_buf_pkg::*;

  logic [WIDTH-1:0] inputD;
  logic             signal;
  logic             validIn;
  logic             readyIn;
  logic [WIDTH-1:0] output1D;
  logic             valid1;
  logic             ready1;
  logic [WIDTH-1:0] output2D;
  logic             valid2;
  logic             ready2;
`ifdef DEMUX_STATS_EN
  logic [DEMUX_STATS_W-1:0] count1;
  logic [DEMUX_STATS_W-1:0] count2;

  modport master (
    output inputD, signal, validIn, ready1, ready2,
    input  readyIn, output1D, valid1, output2D, valid2, count1, count2
  );
  modport slave (
    input  inputD, signal, validIn, ready1, ready2,
    output readyIn, output1D, valid1, output2D, valid2, count1, count2
  );
`else
  modport master (
    output inputD, signal, validIn, ready1, ready2,
    input  readyIn, output1D, valid1, output2D, valid2
  );
  modport slave (
    input  inputD, signal, validIn, ready1, ready2,
    output readyIn, output1D, valid1, output2D, valid2
  );
`endif

endinterface

// File: rtl/demultiplexor4bits_1_2_buf_buffer.sv
// demux_buffer_2entry: 2-entry FIFO with registered head. mem0 is always the
// head so the output needs no read mux; a pop at count 2 shifts mem1 forward.
module demux_buffer_2entry
  import demultiplexor4bits_1_2_buf_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = DEMUX_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             valid
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;
  assign dout    = mem0;

  // Storage: data registers are cleared too so the heads never read as X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) begin
        if (count == '0 || pop_ok) mem0 <= din;
        else                       mem1 <= din;
      end else if (pop_ok && full) begin
        mem0 <= mem1;
      end
    end
  end

endmodule

// File: rtl/demultiplexor4bits_1_2_buf.sv
// Registered 1:2 demultiplexer: steers each accepted word to one of two
// buffered valid/ready ports. Optional DEMUX_STATS_EN adds saturating counters.
module demultiplexor4bits_1_2_buf
  import demultiplexor4bits_1_2_buf_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input logic                          clk,
  input logic                          reset,
  demultiplexor4bits_1_2_buf_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          sel_p1;
  logic          accept;
  logic          full1;
  logic          full2;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;

  assign sel_p1      = (bus.signal == SEL_PORT1);
  // No pop-through: acceptance depends only on the selected buffer's fill level.
  assign bus.readyIn = !reset && (sel_p1 ? !full1 : !full2);
  assign accept      = bus.validIn && bus.readyIn;

  demux_buffer_2entry #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf1 (
    .clk   (clk),
    .rst   (reset),
    .push  (accept && sel_p1),
    .pop   (bus.ready1),
    .din   (bus.inputD),
    .dout  (bus.output1D),
    .count (cnt1),
    .full  (full1),
    .valid (bus.valid1)
  );

  demux_buffer_2entry #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf2 (
    .clk   (clk),
    .rst   (reset),
    .push  (accept && !sel_p1),
    .pop   (bus.ready2),
    .din   (bus.inputD),
    .dout  (bus.output2D),
    .count (cnt2),
    .full  (full2),
    .valid (bus.valid2)
  );

`ifdef DEMUX_STATS_EN
  logic [DEMUX_STATS_W-1:0] stat1;
  logic [DEMUX_STATS_W-1:0] stat2;

  function automatic logic [DEMUX_STATS_W-1:0] sat_inc(input logic [DEMUX_STATS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat1 <= '0;
      stat2 <= '0;
    end else if (accept) begin
      if (sel_p1) stat1 <= sat_inc(stat1);
      else        stat2 <= sat_inc(stat2);
    end
  end

  assign bus.count1 = stat1;
  assign bus.count2 = stat2;
`endif

  // Fill levels are visible through full/valid; the raw counts are only kept for debug.
  logic unused_cnt;
  assign unused_cnt = ^{cnt1, cnt2};

endmodule

// File: tb/tb_demultiplexor4bits_1_2_buf.sv
// Bench for demultiplexor4bits_1_2_buf: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_demultiplexor4bits_1_2_buf;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] q1[$];
  logic [3:0] q2[$];
  int         sc1 = 0;
  int         sc2 = 0;

  always #5 clk = ~clk;

  demultiplexor4bits_1_2_buf_if #(.WIDTH(4)) bus ();

  demultiplexor4bits_1_2_buf #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return bus.signal ? (q1.size() < 2) : (q2.size() < 2);
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic acc;
    @(negedge clk);
    chk("readyIn", 32'(bus.readyIn), 32'(exp_ready()));
    chk("valid1", 32'(bus.valid1), 32'(q1.size() != 0));
    chk("valid2", 32'(bus.valid2), 32'(q2.size() != 0));
    if (q1.size() != 0) chk("data1", 32'(bus.output1D), 32'(q1[0]));
    if (q2.size() != 0) chk("data2", 32'(bus.output2D), 32'(q2[0]));
`ifdef DEMUX_STATS_EN
    chk("count1", 32'(bus.count1), 32'(sc1));
    chk("count2", 32'(bus.count2), 32'(sc2));
`endif
    @(posedge clk);
    acc = bus.validIn && exp_ready();
    if (q1.size() != 0 && bus.ready1) void'(q1.pop_front());
    if (q2.size() != 0 && bus.ready2) void'(q2.pop_front());
    if (acc) begin
      if (bus.signal) begin q1.push_back(bus.inputD); if (sc1 < 255) sc1++; end
      else            begin q2.push_back(bus.inputD); if (sc2 < 255) sc2++; end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] d,
                       input logic r1, input logic r2);
    bus.validIn = v;
    bus.signal  = s;
    bus.inputD  = d;
    bus.ready1  = r1;
    bus.ready2  = r2;
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    sc1 = 0;
    sc2 = 0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readyIn", 32'(bus.readyIn), 32'd0);
    chk("rst_valid1", 32'(bus.valid1), 32'd0);
    chk("rst_valid2", 32'(bus.valid2), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_out1", 32'(bus.output1D), 32'h0);
    chk("idle_out2", 32'(bus.output2D), 32'h0);
    chk("idle_readyIn", 32'(bus.readyIn), 32'd1);
    @(posedge clk); #1;

    // Basic routing
    drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b0, 4'h5, 1'b1, 1'b1); tick();
    chk("route_out2", 32'(bus.output2D), 32'h5);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1); repeat (3) tick();

    // Backpressure on port 1, port 2 independent
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 4'h9, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_readyIn", 32'(bus.readyIn), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
    @(negedge clk);
    chk("p2_readyIn", 32'(bus.readyIn), 32'd1);
    @(posedge clk); #1;
    q2.push_back(4'h3);
    if (sc2 < 255) sc2++;
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1); repeat (4) tick();

    // Push and pop on the same edge at count 1
    drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h8, 1'b0, 1'b1); tick();
    chk("pp_out2", 32'(bus.output2D), 32'h8);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1); tick();
    chk("pp_empty", 32'(bus.valid2), 32'd0);

    // Asynchronous reset with both buffers full
    drive(1'b1, 1'b1, 4'hB, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 1'b0, 4'hC, 1'b0, 1'b0); tick(); tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid1", 32'(bus.valid1), 32'd0);
    chk("arst_valid2", 32'(bus.valid2), 32'd0);
    chk("arst_readyIn", 32'(bus.readyIn), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1); repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 70), 1'($urandom), 4'($urandom),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60));
      tick();
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1); repeat (3) tick();

`ifdef DEMUX_STATS_EN
    // Saturating statistics
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 4'($urandom), 1'b1, 1'b1); tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b1); tick();
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("stat_sat1", 32'(bus.count1), 32'd255);
    chk("stat_cnt2", 32'(bus.count2), 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
